// File: rtl/rv32v_uop_sequencer_if.sv
// Decode/execute-facing bundle of the rv32v micro-op sequencer.
// The master side is decode plus execute; the slave side is the sequencer itself.
interface rv32v_uop_sequencer_if #(
   parameter int LANES = 2
);
   logic             start;
   logic [1:0]       sew;
   logic [2:0]       lmul;
   logic [7:0]       vl;
   logic [7:0]       vstart;
   logic [4:0]       vd;
   logic [4:0]       vs1;
   logic [4:0]       vs2;
   logic             stall;
   logic             flush;
   logic             busy;
   logic             uop_valid;
   logic [4:0]       uop_vd;
   logic [4:0]       uop_vs1;
   logic [4:0]       uop_vs2;
   logic [4:0]       uop_eoff;
   logic [LANES-1:0] uop_mask;
   logic             uop_last;
   logic             done;

   modport master (
      output start, sew, lmul, vl, vstart, vd, vs1, vs2, stall, flush,
      input  busy, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_eoff, uop_mask, uop_last, done
   );

   modport slave (
      input  start, sew, lmul, vl, vstart, vd, vs1, vs2, stall, flush,
      output busy, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_eoff, uop_mask, uop_last, done
   );
endinterface

// File: rtl/rv32v_uop_sequencer.sv
// Walks one vector instruction's element range vstart..vl_eff-1, LANES elements per
// micro-op, never letting a micro-op straddle a register boundary.
module rv32v_uop_sequencer #(
   parameter int VLENB = 16,
   parameter int LANES = 2
) (
   input  logic                     CLK,
   input  logic                     RST,
   rv32v_uop_sequencer_if.slave     bus
);
   localparam int         LG_VLENB = $clog2(VLENB);
   localparam logic [9:0] LANES_W  = 10'(LANES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [4:0]       roff;
      logic [4:0]       eoff;
      logic [LANES-1:0] mask;
      logic [9:0]       step;
      logic             last;
   } uop_t;

   // Lanes past the register boundary are masked; last uses the clipped step so an
   // element in the next register is never skipped.
   function automatic uop_t uop_calc(input logic [8:0] eidx, input logic [3:0] shift,
                                     input logic [8:0] vl_eff);
      uop_t       u;
      logic [9:0] epr;
      logic [9:0] eoff;
      logic [9:0] room;
      epr    = 10'd1 << shift;
      eoff   = {1'b0, eidx} & (epr - 10'd1);
      room   = epr - eoff;
      u.step = (room < LANES_W) ? room : LANES_W;
      u.last = (({1'b0, eidx} + u.step) >= {1'b0, vl_eff});
      u.eoff = 5'(eoff);
      u.roff = 5'(eidx >> shift);
      for (int i = 0; i < LANES; i++) begin
         u.mask[i] = (10'(i) < u.step) && (({1'b0, eidx} + 10'(i)) < {1'b0, vl_eff});
      end
      return u;
   endfunction

   state_t     r_state;
   logic [8:0] r_eidx;
   logic [3:0] r_shift;
   logic [8:0] r_vl_eff;
   logic [4:0] r_vd;
   logic [4:0] r_vs1;
   logic [4:0] r_vs2;
   logic [9:0] r_step;

   logic             r_busy;
   logic             r_uop_valid;
   logic [4:0]       r_uop_vd;
   logic [4:0]       r_uop_vs1;
   logic [4:0]       r_uop_vs2;
   logic [4:0]       r_uop_eoff;
   logic [LANES-1:0] r_uop_mask;
   logic             r_uop_last;
   logic             r_done;

   logic [1:0]  w_sew_eff;
   logic [1:0]  w_regs_lg;
   logic [3:0]  w_start_shift;
   logic [15:0] w_vlmax;
   logic [8:0]  w_start_vl_eff;

   state_t     w_state_nxt;
   logic [8:0] w_eidx_nxt;
   logic [3:0] w_shift_nxt;
   logic [8:0] w_vl_eff_nxt;
   logic [4:0] w_vd_nxt;
   logic [4:0] w_vs1_nxt;
   logic [4:0] w_vs2_nxt;
   uop_t       w_uop_nxt;

   // Geometry of the instruction presented by decode.
   always_comb begin
      w_sew_eff      = (bus.sew == 2'd3) ? 2'd2 : bus.sew;
      w_regs_lg      = bus.lmul[2] ? 2'd0 : bus.lmul[1:0];
      w_start_shift  = 4'(LG_VLENB) - {2'b00, w_sew_eff};
      w_vlmax        = 16'd1 << ({1'b0, w_start_shift} + {3'b000, w_regs_lg});
      w_start_vl_eff = ({8'h00, bus.vl} < w_vlmax) ? {1'b0, bus.vl} : 9'(w_vlmax);
   end

   // Next-state and next-operand logic; flush overrides stall and start.
   always_comb begin
      w_state_nxt  = r_state;
      w_eidx_nxt   = r_eidx;
      w_shift_nxt  = r_shift;
      w_vl_eff_nxt = r_vl_eff;
      w_vd_nxt     = r_vd;
      w_vs1_nxt    = r_vs1;
      w_vs2_nxt    = r_vs2;
      if (bus.flush) begin
         w_state_nxt  = ST_IDLE;
         w_eidx_nxt   = 9'd0;
         w_shift_nxt  = 4'd0;
         w_vl_eff_nxt = 9'd0;
         w_vd_nxt     = 5'd0;
         w_vs1_nxt    = 5'd0;
         w_vs2_nxt    = 5'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  if ({1'b0, bus.vstart} >= w_start_vl_eff) begin
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_state_nxt  = ST_RUN;
                     w_eidx_nxt   = {1'b0, bus.vstart};
                     w_shift_nxt  = w_start_shift;
                     w_vl_eff_nxt = w_start_vl_eff;
                     w_vd_nxt     = bus.vd;
                     w_vs1_nxt    = bus.vs1;
                     w_vs2_nxt    = bus.vs2;
                  end
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (!bus.stall) begin
                  if (r_uop_last) begin
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_eidx_nxt = r_eidx + 9'(r_step);
                  end
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
      w_uop_nxt = uop_calc(w_eidx_nxt, w_shift_nxt, w_vl_eff_nxt);
   end

   // State, operand and registered-output update.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_eidx      <= 9'd0;
         r_shift     <= 4'd0;
         r_vl_eff    <= 9'd0;
         r_vd        <= 5'd0;
         r_vs1       <= 5'd0;
         r_vs2       <= 5'd0;
         r_step      <= 10'd0;
         r_busy      <= 1'b0;
         r_uop_valid <= 1'b0;
         r_uop_vd    <= 5'd0;
         r_uop_vs1   <= 5'd0;
         r_uop_vs2   <= 5'd0;
         r_uop_eoff  <= 5'd0;
         r_uop_mask  <= '0;
         r_uop_last  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_eidx   <= w_eidx_nxt;
         r_shift  <= w_shift_nxt;
         r_vl_eff <= w_vl_eff_nxt;
         r_vd     <= w_vd_nxt;
         r_vs1    <= w_vs1_nxt;
         r_vs2    <= w_vs2_nxt;
         r_busy   <= (w_state_nxt == ST_RUN);
         r_done   <= (w_state_nxt == ST_DONE);
         if (w_state_nxt == ST_RUN) begin
            r_step      <= w_uop_nxt.step;
            r_uop_valid <= 1'b1;
            r_uop_vd    <= w_vd_nxt + w_uop_nxt.roff;
            r_uop_vs1   <= w_vs1_nxt + w_uop_nxt.roff;
            r_uop_vs2   <= w_vs2_nxt + w_uop_nxt.roff;
            r_uop_eoff  <= w_uop_nxt.eoff;
            r_uop_mask  <= w_uop_nxt.mask;
            r_uop_last  <= w_uop_nxt.last;
         end else begin
            r_step      <= 10'd0;
            r_uop_valid <= 1'b0;
            r_uop_vd    <= 5'd0;
            r_uop_vs1   <= 5'd0;
            r_uop_vs2   <= 5'd0;
            r_uop_eoff  <= 5'd0;
            r_uop_mask  <= '0;
            r_uop_last  <= 1'b0;
         end
      end
   end

   assign bus.busy      = r_busy;
   assign bus.uop_valid = r_uop_valid;
   assign bus.uop_vd    = r_uop_vd;
   assign bus.uop_vs1   = r_uop_vs1;
   assign bus.uop_vs2   = r_uop_vs2;
   assign bus.uop_eoff  = r_uop_eoff;
   assign bus.uop_mask  = r_uop_mask;
   assign bus.uop_last  = r_uop_last;
   assign bus.done      = r_done;
endmodule

// File: tb/tb_rv32v_uop_sequencer.sv
// Directed-vector bench for rv32v_uop_sequencer (VLENB=16, LANES=2) with
// hand-computed micro-op tables.
module tb_rv32v_uop_sequencer;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   int         e_roff [16];
   int         e_eoff [16];
   logic [1:0] e_mask [16];

   rv32v_uop_sequencer_if #(.LANES(2)) bus ();

   rv32v_uop_sequencer #(.VLENB(16), .LANES(2)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: sim time expired, required finish");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_exp(input int k, input int roff, input int eoff, input logic [1:0] mask);
      e_roff[k] = roff;
      e_eoff[k] = eoff;
      e_mask[k] = mask;
   endtask

   task automatic check_uop(input string tag, input int k, input int n,
                            input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2);
      logic [4:0] rv;
      rv = 5'(e_roff[k]);
      check_eq({tag, ".valid"}, 32'(bus.uop_valid), 32'd1);
      check_eq({tag, ".busy"}, 32'(bus.busy), 32'd1);
      check_eq({tag, ".vd"}, 32'(bus.uop_vd), 32'(5'(vd + rv)));
      check_eq({tag, ".vs1"}, 32'(bus.uop_vs1), 32'(5'(vs1 + rv)));
      check_eq({tag, ".vs2"}, 32'(bus.uop_vs2), 32'(5'(vs2 + rv)));
      check_eq({tag, ".eoff"}, 32'(bus.uop_eoff), 32'(e_eoff[k]));
      check_eq({tag, ".mask"}, 32'(bus.uop_mask), 32'(e_mask[k]));
      check_eq({tag, ".last"}, 32'(bus.uop_last), 32'(k == n - 1));
      check_eq({tag, ".done"}, 32'(bus.done), 32'd0);
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, ".busy"}, 32'(bus.busy), 32'd0);
      check_eq({tag, ".valid"}, 32'(bus.uop_valid), 32'd0);
      check_eq({tag, ".done"}, 32'(bus.done), 32'd0);
      check_eq({tag, ".mask"}, 32'(bus.uop_mask), 32'd0);
      check_eq({tag, ".last"}, 32'(bus.uop_last), 32'd0);
   endtask

   // Drives one instruction with start for a single edge; returns in cycle N+1.
   task automatic launch(input logic [1:0] sew, input logic [2:0] lmul, input logic [7:0] vl,
                         input logic [7:0] vstart, input logic [4:0] vd, input logic [4:0] vs1,
                         input logic [4:0] vs2);
      bus.sew    = sew;
      bus.lmul   = lmul;
      bus.vl     = vl;
      bus.vstart = vstart;
      bus.vd     = vd;
      bus.vs1    = vs1;
      bus.vs2    = vs2;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
   endtask

   task automatic run_seq(input string tag, input logic [1:0] sew, input logic [2:0] lmul,
                          input logic [7:0] vl, input logic [7:0] vstart, input logic [4:0] vd,
                          input logic [4:0] vs1, input logic [4:0] vs2, input int n);
      launch(sew, lmul, vl, vstart, vd, vs1, vs2);
      for (int k = 0; k < n; k++) begin
         check_uop($sformatf("%s.u%0d", tag, k), k, n, vd, vs1, vs2);
         tick();
      end
      check_eq({tag, ".done"}, 32'(bus.done), 32'd1);
      check_eq({tag, ".done_busy"}, 32'(bus.busy), 32'd0);
      check_eq({tag, ".done_valid"}, 32'(bus.uop_valid), 32'd0);
      tick();
      check_eq({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.sew    = 2'd0;
      bus.lmul   = 3'd0;
      bus.vl     = 8'd0;
      bus.vstart = 8'd0;
      bus.vd     = 5'd0;
      bus.vs1    = 5'd0;
      bus.vs2    = 5'd0;
      bus.stall  = 1'b0;
      bus.flush  = 1'b0;
      tick();
      tick();
      check_idle("reset");
      check_eq("reset.vd", 32'(bus.uop_vd), 32'd0);
      check_eq("reset.eoff", 32'(bus.uop_eoff), 32'd0);
      rst = 1'b0;
      tick();

      // SEW32 LMUL1 vl=4
      set_exp(0, 0, 0, 2'b11);
      set_exp(1, 0, 2, 2'b11);
      run_seq("basic", 2'd2, 3'd0, 8'd4, 8'd0, 5'd3, 5'd1, 5'd2, 2);

      // SEW32 LMUL2 vl=5, vd wraps 31 -> 0
      set_exp(0, 0, 0, 2'b11);
      set_exp(1, 0, 2, 2'b11);
      set_exp(2, 1, 0, 2'b01);
      run_seq("wrap", 2'd2, 3'd1, 8'd5, 8'd0, 5'd31, 5'd10, 5'd20, 3);

      for (int k = 0; k < 8; k++) set_exp(k, 0, 2 * k, 2'b11);
      run_seq("sew8", 2'd0, 3'd0, 8'd16, 8'd0, 5'd8, 5'd9, 5'd7, 8);

      // vl=20 clipped to vlmax=4; sew=3 and fractional lmul behave as SEW32/LMUL1
      set_exp(0, 0, 0, 2'b11);
      set_exp(1, 0, 2, 2'b11);
      run_seq("clip", 2'd2, 3'd0, 8'd20, 8'd0, 5'd4, 5'd5, 5'd6, 2);
      run_seq("sew3frac", 2'd3, 3'd5, 8'd20, 8'd0, 5'd4, 5'd5, 5'd6, 2);

      // SEW16 LMUL4 vl=20: epr 8, third register holds elements 16..19
      for (int k = 0; k < 10; k++) set_exp(k, k / 4, (2 * k) % 8, 2'b11);
      run_seq("sew16", 2'd1, 3'd2, 8'd20, 8'd0, 5'd0, 5'd12, 5'd24, 10);

      // Misaligned vstart=3 in SEW32 LMUL2
      set_exp(0, 0, 3, 2'b01);
      set_exp(1, 1, 0, 2'b11);
      set_exp(2, 1, 2, 2'b11);
      run_seq("misalign", 2'd2, 3'd1, 8'd8, 8'd3, 5'd2, 5'd4, 5'd6, 3);

      // Zero-length: vstart == vl
      launch(2'd2, 3'd0, 8'd4, 8'd4, 5'd1, 5'd1, 5'd1);
      check_eq("zero.done", 32'(bus.done), 32'd1);
      check_eq("zero.busy", 32'(bus.busy), 32'd0);
      check_eq("zero.valid", 32'(bus.uop_valid), 32'd0);
      tick();
      check_idle("zero.after");

      // Stall 3 cycles on the second micro-op; done in N+6
      set_exp(0, 0, 0, 2'b11);
      set_exp(1, 0, 2, 2'b11);
      launch(2'd2, 3'd0, 8'd4, 8'd0, 5'd3, 5'd1, 5'd2);
      check_uop("stall.u0", 0, 2, 5'd3, 5'd1, 5'd2);
      tick();
      bus.stall = 1'b1;
      check_uop("stall.n2", 1, 2, 5'd3, 5'd1, 5'd2);
      tick();
      check_uop("stall.n3", 1, 2, 5'd3, 5'd1, 5'd2);
      tick();
      check_uop("stall.n4", 1, 2, 5'd3, 5'd1, 5'd2);
      tick();
      bus.stall = 1'b0;
      check_uop("stall.n5", 1, 2, 5'd3, 5'd1, 5'd2);
      tick();
      check_eq("stall.done", 32'(bus.done), 32'd1);
      check_eq("stall.busy", 32'(bus.busy), 32'd0);
      tick();

      // Flush during the second micro-op, then a fresh instruction from vstart=6
      for (int k = 0; k < 8; k++) set_exp(k, 0, 2 * k, 2'b11);
      launch(2'd0, 3'd0, 8'd16, 8'd0, 5'd8, 5'd9, 5'd7);
      tick();
      check_uop("flush.u1", 1, 8, 5'd8, 5'd9, 5'd7);
      bus.flush = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.flush = 1'b0;
      bus.start = 1'b0;
      check_idle("flush.n");
      tick();
      check_idle("flush.n1");
      for (int k = 0; k < 5; k++) set_exp(k, 0, 6 + 2 * k, 2'b11);
      run_seq("post_flush", 2'd0, 3'd0, 8'd16, 8'd6, 5'd11, 5'd12, 5'd13, 5);

      // Reset during the second micro-op, then SEW16 vl=8 vstart=2
      for (int k = 0; k < 8; k++) set_exp(k, 0, 2 * k, 2'b11);
      launch(2'd0, 3'd0, 8'd16, 8'd0, 5'd8, 5'd9, 5'd7);
      tick();
      check_uop("rst.u1", 1, 8, 5'd8, 5'd9, 5'd7);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst.n");
      check_eq("rst.vd", 32'(bus.uop_vd), 32'd0);
      tick();
      check_idle("rst.n1");
      for (int k = 0; k < 3; k++) set_exp(k, 0, 2 + 2 * k, 2'b11);
      run_seq("post_rst", 2'd1, 3'd0, 8'd8, 8'd2, 5'd5, 5'd6, 5'd7, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
